// File: rtl/project_triangle_seq_if.sv
// rtl/project_triangle_seq_if.sv - triangle/MVP input handshake and pixel result bundle
interface project_triangle_seq_if #(
  parameter int WII = 8,
  parameter int WIF = 8,
  parameter int WS  = 10
);
  localparam int W = WII + WIF;

  logic                  in_valid;
  logic                  in_ready;
  logic [3:0][W-1:0]     vertex_a;
  logic [3:0][W-1:0]     vertex_b;
  logic [3:0][W-1:0]     vertex_c;
  logic [15:0][W-1:0]    mvp;
  logic [WS-1:0]         width;
  logic [WS-1:0]         height;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0][WS-1:0]    V1;
  logic [1:0][WS-1:0]    V2;
  logic [1:0][WS-1:0]    V3;
  logic                  culled;
  logic                  clamped;
  logic                  overflow;

  modport slave (
    input  in_valid, vertex_a, vertex_b, vertex_c, mvp, width, height, out_ready,
    output in_ready, out_valid, V1, V2, V3, culled, clamped, overflow
  );

  modport master (
    output in_valid, vertex_a, vertex_b, vertex_c, mvp, width, height, out_ready,
    input  in_ready, out_valid, V1, V2, V3, culled, clamped, overflow
  );
endinterface

// File: rtl/project_triangle_seq.sv
// rtl/project_triangle_seq.sv - sequential triangle projector: one MAC and one restoring divider
module project_triangle_seq #(
  parameter int WII = 8,
  parameter int WIF = 8,
  parameter int WS  = 10
) (
  input logic Clk,
  input logic Reset,
  project_triangle_seq_if.slave bus
);
  localparam int W  = WII + WIF;
  localparam int AW = 2 * W + 2;
  localparam int NQ = W + WIF;
  localparam int CW = ($clog2(NQ) > 4) ? $clog2(NQ) : 4;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, DOT, DIVX, DIVY, MAP, DONE} state_t;

  state_t                  state;
  logic                    in_ready_q, out_valid_q, culled_q, clamped_q, overflow_q;
  logic [CW-1:0]           cnt;
  logic [1:0]              vidx;
  logic [2:0][3:0][W-1:0]  vert;
  logic [15:0][W-1:0]      mat;
  logic [WS-1:0]           wid, hgt;
  logic [AW-1:0]           acc;
  logic [W-1:0]            cx, cy, cw, ndc_x, ndc_y;
  logic [NQ-1:0]           dq;
  logic [W-1:0]            rem;
  logic [2:0][1:0][WS-1:0] pix;

  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  logic [1:0]        row;
  logic [W-1:0]      ma, vb;
  logic [2*W-1:0]    prod;
  logic [AW-1:0]     acc_sum;
  logic signed [AW:0] rnd, shr;
  logic              row_fit;
  logic [W-1:0]      row_val;

  // Row 2 (clip z) is skipped: counter rows 0,1,2 map to matrix rows 0,1,3.
  always_comb begin
    row     = (cnt[3:2] == 2'd2) ? 2'd3 : cnt[3:2];
    ma      = mat[{row, cnt[1:0]}];
    vb      = vert[vidx][cnt[1:0]];
    prod    = {{W{ma[W-1]}}, ma} * {{W{vb[W-1]}}, vb};
    acc_sum = acc + {{2{prod[2*W-1]}}, prod};
    rnd     = {acc_sum[AW-1], acc_sum} + ((AW+1)'(1) << (WIF - 1));
    shr     = rnd >>> WIF;
    row_fit = (&shr[AW:W-1]) | ~(|shr[AW:W-1]);
    row_val = row_fit ? shr[W-1:0] : (shr[AW] ? SMIN : SMAX);
  end

  logic [W:0]    rem_sh;
  logic [W-1:0]  rem_nx;
  logic          qbit, div_neg, w_pos, div_ovf;
  logic [NQ-1:0] q_fin;
  logic [W-1:0]  div_val;

  always_comb begin
    rem_sh  = {rem, dq[NQ-1]};
    qbit    = rem_sh >= {1'b0, cw};
    rem_nx  = qbit ? W'(rem_sh - {1'b0, cw}) : rem_sh[W-1:0];
    q_fin   = {dq[NQ-2:0], qbit};
    div_neg = (state == DIVY) ? cy[W-1] : cx[W-1];
    w_pos   = !cw[W-1] && (cw != '0);
    div_ovf = 1'b0;
    div_val = '0;
    if (w_pos) begin
      if (!div_neg && q_fin > NQ'(SMAX)) begin
        div_val = SMAX;
        div_ovf = 1'b1;
      end else if (div_neg && q_fin > NQ'(SMIN)) begin
        div_val = SMIN;
        div_ovf = 1'b1;
      end else begin
        div_val = div_neg ? (~q_fin[W-1:0] + W'(1)) : q_fin[W-1:0];
      end
    end
  end

  logic [W-1:0]    ndc;
  logic [WS-1:0]   size, size_m1, map_val;
  logic [W:0]      t;
  logic [W+WS-1:0] mp, pf;
  logic            map_clamp;

  always_comb begin
    ndc       = cnt[0] ? ndc_y : ndc_x;
    size      = cnt[0] ? hgt : wid;
    size_m1   = size - WS'(1);
    t         = {ndc[W-1], ndc} + ((W+1)'(1) << WIF);
    mp        = {{WS{1'b0}}, t[W-1:0]} * {{W{1'b0}}, size};
    pf        = mp >> (WIF + 1);
    map_clamp = 1'b0;
    map_val   = pf[WS-1:0];
    if (t[W]) begin
      map_val   = '0;
      map_clamp = 1'b1;
    end else if (pf > {{W{1'b0}}, size_m1}) begin
      map_val   = size_m1;
      map_clamp = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      culled_q    <= 1'b0;
      clamped_q   <= 1'b0;
      overflow_q  <= 1'b0;
      pix         <= '0;
      cnt         <= '0;
      vidx        <= '0;
      acc         <= '0;
      dq          <= '0;
      rem         <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          vert       <= {bus.vertex_c, bus.vertex_b, bus.vertex_a};
          mat        <= bus.mvp;
          wid        <= bus.width;
          hgt        <= bus.height;
          culled_q   <= 1'b0;
          clamped_q  <= 1'b0;
          overflow_q <= 1'b0;
          in_ready_q <= 1'b0;
          cnt        <= '0;
          vidx       <= '0;
          acc        <= '0;
          state      <= DOT;
        end
        DOT: begin
          if (cnt[1:0] == 2'd3) begin
            acc <= '0;
            if (!row_fit) overflow_q <= 1'b1;
            case (cnt[3:2])
              2'd0:    cx <= row_val;
              2'd1:    cy <= row_val;
              default: cw <= row_val;
            endcase
          end else begin
            acc <= acc_sum;
          end
          if (cnt == CW'(11)) begin
            cnt   <= '0;
            dq    <= {mag(cx), {WIF{1'b0}}};
            rem   <= '0;
            state <= DIVX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DIVX, DIVY: begin
          dq  <= q_fin;
          rem <= rem_nx;
          if (cnt == CW'(NQ - 1)) begin
            cnt <= '0;
            rem <= '0;
            if (div_ovf) overflow_q <= 1'b1;
            if (!w_pos)  culled_q   <= 1'b1;
            if (state == DIVX) begin
              ndc_x <= div_val;
              dq    <= {mag(cy), {WIF{1'b0}}};
              state <= DIVY;
            end else begin
              ndc_y <= div_val;
              state <= MAP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        MAP: begin
          pix[vidx][cnt[0]] <= w_pos ? map_val : '0;
          if (w_pos && map_clamp) clamped_q <= 1'b1;
          if (cnt[0]) begin
            cnt <= '0;
            if (vidx == 2'd2) begin
              out_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              vidx  <= vidx + 2'd1;
              state <= DOT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.V1        = pix[0];
  assign bus.V2        = pix[1];
  assign bus.V3        = pix[2];
  assign bus.culled    = culled_q;
  assign bus.clamped   = clamped_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_project_triangle_seq.sv
// tb/tb_project_triangle_seq.sv - scoreboard bench for project_triangle_seq
module tb_project_triangle_seq;
  localparam int WII = 8;
  localparam int WIF = 8;
  localparam int WS  = 10;
  localparam int W   = WII + WIF;

  typedef logic [3:0][W-1:0]  vtx_t;
  typedef logic [15:0][W-1:0] mat_t;
  typedef logic [1:0][WS-1:0] pix_t;
  typedef struct {
    pix_t v1, v2, v3;
    logic cul, clp, ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  project_triangle_seq_if #(.WII(WII), .WIF(WIF), .WS(WS)) bus();
  project_triangle_seq #(.WII(WII), .WIF(WIF), .WS(WS)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_vtx(input vtx_t v, input mat_t m, input int wd, input int ht,
                                    output pix_t px, inout logic cul, inout logic clp, inout logic ovf);
    longint clip[3];
    longint s, q, t, p, sz;
    int     r;
    px = '0;
    for (int i = 0; i < 3; i++) begin
      r = (i == 2) ? 3 : i;
      s = 0;
      for (int c = 0; c < 4; c++)
        s += longint'($signed(m[4*r+c])) * longint'($signed(v[c]));
      s = (s + 128) >>> 8;
      if (s > 32767) begin s = 32767; ovf = 1'b1; end
      else if (s < -32768) begin s = -32768; ovf = 1'b1; end
      clip[i] = s;
    end
    if (clip[2] <= 0) begin
      cul = 1'b1;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      q = ((clip[k] < 0 ? -clip[k] : clip[k]) * 256) / clip[2];
      if (clip[k] < 0) q = -q;
      if (q > 32767) begin q = 32767; ovf = 1'b1; end
      else if (q < -32768) begin q = -32768; ovf = 1'b1; end
      sz = (k == 0) ? wd : ht;
      t  = q + 256;
      if (t < 0) begin
        p = 0;
        clp = 1'b1;
      end else begin
        p = (t * sz) >>> 9;
        if (p > sz - 1) begin p = sz - 1; clp = 1'b1; end
      end
      px[k] = p[WS-1:0];
    end
  endfunction

  function automatic exp_t model_tri(input vtx_t a, input vtx_t b, input vtx_t c, input mat_t m,
                                     input int wd, input int ht);
    exp_t e;
    logic cul, clp, ovf;
    pix_t p1, p2, p3;
    cul = 1'b0; clp = 1'b0; ovf = 1'b0;
    model_vtx(a, m, wd, ht, p1, cul, clp, ovf);
    model_vtx(b, m, wd, ht, p2, cul, clp, ovf);
    model_vtx(c, m, wd, ht, p3, cul, clp, ovf);
    e.v1 = p1; e.v2 = p2; e.v3 = p3;
    e.cul = cul; e.clp = clp; e.ovf = ovf;
    return e;
  endfunction

  function automatic vtx_t mk(input int x, input int y, input int z, input int w);
    vtx_t v;
    v[0] = W'(x); v[1] = W'(y); v[2] = W'(z); v[3] = W'(w);
    return v;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    for (int i = 0; i < 16; i++) m[i] = (i % 5 == 0) ? 16'h0100 : 16'h0000;
    return m;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int i = 0; i < 16; i++) m[i] = W'(int'($urandom_range(0, 1024)) - 512);
    return m;
  endfunction

  function automatic vtx_t rnd_vtx();
    return mk(int'($urandom_range(0, 2048)) - 1024, int'($urandom_range(0, 2048)) - 1024,
              int'($urandom_range(0, 2048)) - 1024, int'($urandom_range(0, 1088)) - 64);
  endfunction

  task automatic send(input vtx_t a, input vtx_t b, input vtx_t c, input mat_t m,
                      input int wd, input int ht);
    chk("ready_before_accept", bus.in_ready, 1);
    bus.vertex_a = a; bus.vertex_b = b; bus.vertex_c = c; bus.mvp = m;
    bus.width = WS'(wd); bus.height = WS'(ht);
    bus.in_valid = 1'b1;
    sb.push_back(model_tri(a, b, c, m, wd, ht));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("ready_low_after_accept", bus.in_ready, 0);
  endtask

  task automatic wait_out();
    int   n;
    exp_t e;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 187);
    e = sb.pop_front();
    chk("V1", bus.V1, e.v1);
    chk("V2", bus.V2, e.v2);
    chk("V3", bus.V3, e.v3);
    chk("culled", bus.culled, e.cul);
    chk("clamped", bus.clamped, e.clp);
    chk("overflow", bus.overflow, e.ovf);
  endtask

  task automatic finish_out();
    @(posedge clk); #1;
    chk("valid_drop_after_hs", bus.out_valid, 0);
    chk("ready_after_hs", bus.in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mat_t        m;
    vtx_t        ra, rb, rc;
    logic [62:0] snap;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.vertex_a = '0; bus.vertex_b = '0; bus.vertex_c = '0;
    bus.mvp = ident(); bus.width = 10'd640; bus.height = 10'd480;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_pixels", {bus.V1, bus.V2, bus.V3}, 0);
    chk("rst_flags", {bus.culled, bus.clamped, bus.overflow}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic projection
    send(mk(128, -128, 0, 256), mk(0, 0, 0, 256), mk(-64, 192, 0, 256), ident(), 640, 480);
    wait_out();
    chk("basic_V1", bus.V1, {10'd120, 10'd480});
    chk("basic_flags", {bus.culled, bus.clamped, bus.overflow}, 0);
    finish_out();

    // w = 0 on vertex b
    send(mk(128, -128, 0, 256), mk(64, 64, 0, 0), mk(-64, 192, 0, 256), ident(), 640, 480);
    wait_out();
    chk("cull_flag", bus.culled, 1);
    chk("cull_V2", bus.V2, 0);
    finish_out();

    // off-screen clamp
    send(mk(128, -128, 0, 256), mk(0, 0, 0, 256), mk(512, -768, 0, 256), ident(), 640, 480);
    wait_out();
    chk("clamp_V3", bus.V3, {10'd0, 10'd639});
    chk("clamp_flag", bus.clamped, 1);
    finish_out();

    // dot-product saturation
    m = ident();
    m[0] = 16'd25600;
    send(mk(25600, 0, 0, 256), mk(0, 64, 0, 256), mk(0, -64, 0, 256), m, 640, 480);
    wait_out();
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_V1x", bus.V1[0], 639);
    chk("ovf_clamp", bus.clamped, 1);
    finish_out();

    // backpressure, with inputs disturbed while in flight
    bus.out_ready = 1'b0;
    m = rnd_mat();
    ra = mk(300, -200, 100, 512); rb = mk(-100, 50, 0, 384); rc = mk(20, 700, -30, 300);
    send(ra, rb, rc, m, 640, 480);
    bus.width = 10'd100; bus.height = 10'd50;
    bus.vertex_a = mk(7, 7, 7, 7); bus.mvp = rnd_mat();
    wait_out();
    snap = {bus.V1, bus.V2, bus.V3, bus.culled, bus.clamped, bus.overflow};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("hold_outputs", {bus.V1, bus.V2, bus.V3, bus.culled, bus.clamped, bus.overflow}, snap);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    finish_out();

    // reset during vertex b DIVX
    send(mk(128, -128, 0, 256), mk(0, 0, 0, 256), mk(-64, 192, 0, 256), ident(), 640, 480);
    repeat (79) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    sb.delete();
    send(mk(-128, 128, 0, 256), mk(64, -64, 0, 512), mk(0, 0, 0, 256), ident(), 320, 200);
    wait_out();
    finish_out();

    for (int i = 0; i < 3; i++) begin
      m = rnd_mat();
      ra = rnd_vtx(); rb = rnd_vtx(); rc = rnd_vtx();
      send(ra, rb, rc, m, int'($urandom_range(1, 1023)), int'($urandom_range(1, 1023)));
      wait_out();
      finish_out();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
